// File: rtl/typhoon_pkg.sv
// typhoon_pkg: shared types and defaults for the framebuffer scanout path.
package typhoon_pkg;
    typedef enum logic [1:0] {IDLE, REQ, WAIT} fetch_state_t;
    typedef struct packed {
        logic [4:0] r;
        logic [5:0] g;
        logic [4:0] b;
    } rgb565_t;
    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_V_ACTIVE = 480;
    // Replicate MSBs into the low bits so full-scale 565 maps to full-scale 888.
    function automatic logic [23:0] rgb888(rgb565_t p);
        return {p.r, p.r[4:2], p.g, p.g[5:4], p.b, p.b[4:2]};
    endfunction
endpackage

// File: rtl/scanout_fifo.sv
// scanout_fifo: synchronous show-ahead FIFO with flush; push on full is accepted only alongside a pop.
module scanout_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 16
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_flush,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_data,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_empty,
    output logic                     o_full
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr, r_rd;
    logic [CW-1:0]    r_count;
    logic             w_push, w_pop;
    assign o_count = r_count;
    assign o_empty = r_count == '0;
    assign o_full  = r_count == CW'(DEPTH);
    assign o_data  = r_mem[r_rd];
    assign w_pop   = i_pop && !o_empty;
    assign w_push  = i_push && (!o_full || w_pop);
    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wr] <= i_data;
    end
    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            r_wr    <= r_wr + AW'(w_push);
            r_rd    <= r_rd + AW'(w_pop);
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end
endmodule

// File: rtl/framebuffer_scanout.sv
// framebuffer_scanout: prefetches RGB565 words from SRAM and pops one per active pixel onto 8:8:8 VGA outputs.
// The front buffer is chosen at each frame boundary; at most one SRAM read is outstanding.
module framebuffer_scanout
    import typhoon_pkg::*;
#(
    parameter int          H_ACTIVE   = DEF_H_ACTIVE,
    parameter int          V_ACTIVE   = DEF_V_ACTIVE,
    parameter int          FIFO_DEPTH = 16,
    parameter logic [19:0] BUF0_BASE  = 20'h00000,
    parameter logic [19:0] BUF1_BASE  = 20'h4B000
) (
    input  logic        BOARD_CLK,
    input  logic        Reset,
    input  logic [9:0]  VGA_SCAN_X,
    input  logic [9:0]  VGA_SCAN_Y,
    input  logic        doubleBuffer,
    input  logic [15:0] framebufferData,
    input  logic        dataReady,
    output logic [19:0] framebufferAddress,
    output logic        queueRead,
    output logic [7:0]  VGA_R,
    output logic [7:0]  VGA_G,
    output logic [7:0]  VGA_B,
    output logic        underflow
);
    localparam logic [9:0]  H_LIM = 10'(H_ACTIVE);
    localparam logic [9:0]  V_LIM = 10'(V_ACTIVE);
    localparam logic [18:0] TOTAL = 19'(H_ACTIVE * V_ACTIVE);
    localparam int          CW    = $clog2(FIFO_DEPTH) + 1;
    fetch_state_t  r_state, w_next;
    logic [9:0]    r_prev_x, r_prev_y;
    logic [18:0]   r_word_cnt, r_skip;
    logic [19:0]   r_addr;
    logic [23:0]   r_rgb;
    logic          r_buf_sel, r_discard, r_queue_read, r_underflow;
    logic          w_active, w_adv, w_frame, w_issue, w_ret, w_keep;
    logic          w_push, w_pop, w_starve, w_drop_skip, w_empty, w_full;
    logic [CW-1:0] w_count;
    rgb565_t       w_head;
    assign w_active    = (VGA_SCAN_X < H_LIM) && (VGA_SCAN_Y < V_LIM);
    assign w_adv       = w_active && (VGA_SCAN_X != r_prev_x || VGA_SCAN_Y != r_prev_y);
    assign w_frame     = (VGA_SCAN_Y >= V_LIM) && (r_prev_y < V_LIM);
    assign w_issue     = r_state == REQ && !w_frame && w_count < CW'(FIFO_DEPTH);
    assign w_ret       = r_state == WAIT && dataReady;
    // A returning word belongs to the current frame only if no boundary intervened.
    assign w_keep      = w_ret && !r_discard && !w_frame;
    assign w_drop_skip = w_keep && r_skip != '0;
    assign w_pop       = w_adv && !w_empty;
    assign w_starve    = w_adv && w_empty;
    assign w_push      = w_keep && r_skip == '0 && (!w_full || w_pop);
    scanout_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(16)) u_fifo (
        .i_clk   (BOARD_CLK),
        .i_rst   (Reset),
        .i_flush (w_frame),
        .i_push  (w_push),
        .i_data  (framebufferData),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_count (w_count),
        .o_empty (w_empty),
        .o_full  (w_full)
    );
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    w_next = w_frame ? REQ : IDLE;
            REQ:     w_next = w_issue ? WAIT : REQ;
            WAIT:    w_next = !w_ret ? WAIT : (w_frame || r_word_cnt != TOTAL) ? REQ : IDLE;
            default: w_next = IDLE;
        endcase
    end
    always_ff @(posedge BOARD_CLK) begin
        if (Reset) begin
            r_state      <= IDLE;
            r_prev_x     <= V_LIM;
            r_prev_y     <= V_LIM;
            r_word_cnt   <= '0;
            r_skip       <= '0;
            r_addr       <= '0;
            r_rgb        <= '0;
            r_buf_sel    <= 1'b0;
            r_discard    <= 1'b0;
            r_queue_read <= 1'b0;
            r_underflow  <= 1'b0;
        end else begin
            r_state      <= w_next;
            r_prev_x     <= VGA_SCAN_X;
            r_prev_y     <= VGA_SCAN_Y;
            r_queue_read <= w_issue;
            r_word_cnt   <= w_frame ? '0 : r_word_cnt + 19'(w_issue);
            r_skip       <= w_frame ? '0 : r_skip + 19'(w_starve && r_skip != '1) - 19'(w_drop_skip);
            r_discard    <= w_ret ? 1'b0 : (w_frame && r_state == WAIT) ? 1'b1 : r_discard;
            r_underflow  <= r_underflow || w_starve;
            r_rgb        <= w_adv ? (w_empty ? 24'h0 : rgb888(w_head)) : (w_active ? r_rgb : 24'h0);
            if (w_issue) r_addr <= (r_buf_sel ? BUF1_BASE : BUF0_BASE) + {1'b0, r_word_cnt};
            if (w_frame) r_buf_sel <= doubleBuffer;
        end
    end
    assign queueRead          = r_queue_read;
    assign framebufferAddress = r_addr;
    assign underflow          = r_underflow;
    assign {VGA_R, VGA_G, VGA_B} = r_rgb;
endmodule

// File: tb/tb_framebuffer_scanout.sv
// tb_framebuffer_scanout: directed checks of fetch, pixel expansion, buffer select, underflow skip and full frame.
module tb_framebuffer_scanout;
    localparam int H = 16;
    localparam int V = 4;
    logic        clk = 1'b0;
    logic        Reset = 1'b1;
    logic [9:0]  X = 10'(H);
    logic [9:0]  Y = 10'(V);
    logic        doubleBuffer = 1'b0;
    logic [15:0] framebufferData = '0;
    logic        dataReady = 1'b0;
    logic [19:0] framebufferAddress;
    logic        queueRead, underflow;
    logic [7:0]  VGA_R, VGA_G, VGA_B;
    int          total = 0, bad = 0, nreq = 0, n_overlap = 0;
    logic [19:0] first_addr = '0, last_addr = '0, pend_addr = '0;
    logic        pend = 1'b0, hold = 1'b0;

    framebuffer_scanout #(.H_ACTIVE(H), .V_ACTIVE(V), .FIFO_DEPTH(16)) dut (
        .BOARD_CLK          (clk),
        .Reset              (Reset),
        .VGA_SCAN_X         (X),
        .VGA_SCAN_Y         (Y),
        .doubleBuffer       (doubleBuffer),
        .framebufferData    (framebufferData),
        .dataReady          (dataReady),
        .framebufferAddress (framebufferAddress),
        .queueRead          (queueRead),
        .VGA_R              (VGA_R),
        .VGA_G              (VGA_G),
        .VGA_B              (VGA_B),
        .underflow          (underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] mdata(input logic [19:0] a);
        return (a == 20'h0) ? 16'hF800 : (a == 20'h1) ? 16'h07E0 : a[15:0];
    endfunction

    function automatic logic [23:0] exp_rgb(input logic [15:0] d);
        return {d[15:11], d[15:13], d[10:5], d[10:9], d[4:0], d[4:2]};
    endfunction

    // One clock; the SRAM model answers a request on the cycle after it is seen unless held.
    task automatic tick();
        @(posedge clk);
        #1;
        dataReady = 1'b0;
        if (queueRead) begin
            nreq++;
            last_addr = framebufferAddress;
            if (nreq == 1) first_addr = framebufferAddress;
            if (pend) n_overlap++;
            pend = 1'b1;
            pend_addr = framebufferAddress;
        end else if (pend && !hold) begin
            dataReady = 1'b1;
            framebufferData = mdata(pend_addr);
            pend = 1'b0;
        end
    endtask

    task automatic px(input int x, input int y);
        X = 10'(x);
        Y = 10'(y);
        tick();
    endtask

    function automatic logic [31:0] rgb();
        return {8'h0, VGA_R, VGA_G, VGA_B};
    endfunction

    initial begin
        repeat (3) tick();
        chk("rst_qr", 32'(queueRead), 0);
        chk("rst_addr", 32'(framebufferAddress), 0);
        chk("rst_rgb", rgb(), 0);
        chk("rst_uf", 32'(underflow), 0);
        Reset = 1'b0;
        repeat (5) tick();
        chk("idle_noreq", nreq, 0);
        // Prefetch fills exactly the FIFO while the scan sits in blanking.
        px(H, 0);
        px(H, V);
        repeat (100) tick();
        chk("fill_nreq", nreq, 16);
        chk("fill_first", 32'(first_addr), 32'h0);
        chk("fill_last", 32'(last_addr), 32'hF);
        chk("fill_overlap", n_overlap, 0);
        px(0, 0);
        chk("px_red", rgb(), 32'hFF0000);
        px(1, 0);
        chk("px_green", rgb(), 32'h00FF00);
        tick();
        chk("px_hold", rgb(), 32'h00FF00);
        chk("px_no_uf", 32'(underflow), 0);
        // Buffer 1 selected at the boundary; a mid-frame toggle must not move addresses.
        doubleBuffer = 1'b1;
        nreq = 0;
        px(H, V);
        repeat (60) tick();
        chk("db_first", 32'(first_addr), 32'h4B000);
        doubleBuffer = 1'b0;
        px(0, 0);
        chk("db_px0", rgb(), 32'hB50000);
        px(1, 0);
        px(2, 0);
        px(3, 0);
        repeat (20) tick();
        chk("db_toggle_addr", 32'(last_addr), 32'h4B013);
        // Starve the first three pixels of a frame.
        hold = 1'b1;
        px(H, V);
        repeat (3) tick();
        px(0, 0);
        chk("uf_rgb0", rgb(), 0);
        chk("uf_set", 32'(underflow), 1);
        px(1, 0);
        px(2, 0);
        chk("uf_rgb2", rgb(), 0);
        hold = 1'b0;
        repeat (70) tick();
        px(3, 0);
        chk("uf_word3", rgb(), 32'h000018);
        px(4, 0);
        chk("uf_word4", rgb(), 32'h000021);
        chk("uf_sticky", 32'(underflow), 1);
        repeat (12) tick();
        // Reset while a read is outstanding, then a late dataReady.
        hold = 1'b1;
        nreq = 0;
        px(H, V);
        repeat (2) tick();
        chk("wait_req", nreq, 1);
        chk("wait_addr", 32'(pend_addr), 32'h0);
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        chk("mid_rst_uf", 32'(underflow), 0);
        chk("mid_rst_qr", 32'(queueRead), 0);
        tick();
        dataReady = 1'b1;
        framebufferData = 16'h1234;
        tick();
        pend = 1'b0;
        hold = 1'b0;
        nreq = 0;
        repeat (10) tick();
        chk("late_noreq", nreq, 0);
        px(0, 0);
        chk("late_rgb", rgb(), 0);
        chk("late_empty_uf", 32'(underflow), 1);
        chk("late_noreq2", nreq, 0);
        // Full frame from buffer 0.
        nreq = 0;
        px(H, V);
        repeat (60) tick();
        for (int y = 0; y < V; y++) begin
            for (int x = 0; x < H; x++) begin
                px(x, y);
                chk("frame_px", rgb(), {8'h0, exp_rgb(mdata(20'(y * H + x)))});
                repeat (3) tick();
            end
        end
        repeat (20) tick();
        chk("frame_nreq", nreq, H * V);
        chk("frame_last", 32'(last_addr), 32'(H * V - 1));
        repeat (50) tick();
        chk("frame_idle", nreq, H * V);
        chk("frame_overlap", n_overlap, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/framebuffer_scanout.md
# framebuffer_scanout

Streams the displayed framebuffer from SRAM to the VGA colour outputs. It occupies one client port of `SRAM_controller`, prefetches RGB565 words into a small FIFO, and pops one word per active pixel as the `VGA_controller` scan coordinates advance. It expands each word to 8:8:8 on `VGA_R/G/B` and selects the front buffer from `doubleBuffer` at each frame boundary.

## Interface
- `H_ACTIVE`, default 640: active pixels per line.
- `V_ACTIVE`, default 480: active lines per frame.
- `FIFO_DEPTH`, default 16: prefetch FIFO depth in words; must be a power of two, ≥4.
- `BUF0_BASE`, default 20'h00000: word address of buffer 0.
- `BUF1_BASE`, default 20'h4B000: word address of buffer 1, equal to 640*480.
- `BOARD_CLK`  in  1  sole clock; all logic on its rising edge.
- `Reset`  in  1  synchronous, active-high reset.
- `VGA_SCAN_X`  in  10  current scan column from `VGA_controller`.
- `VGA_SCAN_Y`  in  10  current scan line from `VGA_controller`.
- `doubleBuffer`  in  1  buffer select (0 = `BUF0_BASE`, 1 = `BUF1_BASE`); sampled only at frame boundary.
- `framebufferData`  in  16  SRAM read data; valid only while `dataReady`=1.
- `dataReady`  in  1  one-cycle pulse completing the outstanding read.
- `framebufferAddress`  out  20  read address; valid while `queueRead`=1.
- `queueRead`  out  1  one-cycle read request to the SRAM controller port.
- `VGA_R`, `VGA_G`, `VGA_B`  out  8 each  pixel colour; 0 outside the active region.
- `underflow`  out  1  sticky flag, set when an active pixel found the FIFO empty.

## Operation
- Active region is `VGA_SCAN_X < H_ACTIVE && VGA_SCAN_Y < V_ACTIVE`.
- Pixel advance is a cycle where `VGA_SCAN_X`/`VGA_SCAN_Y` differ from their registered previous values and the new coordinate is active.
- Frame boundary is the first cycle with `VGA_SCAN_Y ≥ V_ACTIVE` after a cycle with `VGA_SCAN_Y < V_ACTIVE`. At a frame boundary the block:
  - flushes the FIFO;
  - clears the word counter;
  - latches `doubleBuffer` into `buf_sel`;
  - clears the skip counter;
  - marks any outstanding read as discard.
- Fetch FSM:
  - IDLE: after reset, and after H_ACTIVE*V_ACTIVE words have been issued. Leaves only on a frame boundary, to REQ.
  - REQ: if `fifo_count` < FIFO_DEPTH, the block pulses `queueRead` with `framebufferAddress` = base(`buf_sel`) + `word_cnt`, increments `word_cnt`, and goes to WAIT. Otherwise it holds in REQ.
  - WAIT: on `dataReady`, the word is pushed to the FIFO unless it is discarded (discard flag set, or skip counter > 0, which is then decremented). Next state is IDLE if `word_cnt` = H_ACTIVE*V_ACTIVE, else REQ.
- At most one read is outstanding. `dataReady` outside WAIT is ignored.
- Pixel pop: on each pixel advance, pop one FIFO word.
  - Output expansion: R = {d[15:11], d[15:13]}, G = {d[10:5], d[10:9]}, B = {d[4:0], d[4:2]}.
  - If the FIFO is empty: output 0, set `underflow`, increment the skip counter (saturating at 2^19−1) so later words stay pixel-aligned.
- Outside the active region, RGB is registered to 0.
- `word_cnt` is 19 bits. Address sum is 20-bit, no wrap checking; bases are set so both buffers fit.

## Timing
- Reset values:
  - `queueRead`=0, `framebufferAddress`=0, RGB=0, `underflow`=0.
  - FSM=IDLE, FIFO empty, `buf_sel`=0, previous-coordinate registers = V_ACTIVE, skip counter=0.
- Request issue: `queueRead` follows REQ entry by 1 cycle minimum. Back-to-back reads are spaced by ≥1 cycle (REQ→WAIT→REQ).
- Pixel latency: RGB is valid in the cycle after the pixel advance.
- A word pushed in cycle n is poppable in cycle n+1. If a push and a pop coincide on an empty FIFO, the result is an underflow; the pushed word is retained.
- A push and a pop on a full FIFO in the same cycle are legal. The count stays unchanged.
- Reset mid-WAIT returns the FSM to IDLE. A late `dataReady` is ignored and nothing is pushed.
- A frame boundary during WAIT: the FSM remains in WAIT, the returning word is discarded, then it enters REQ at the new base.

## Structure
- Package `typhoon_pkg`: `fetch_state_t` (IDLE, REQ, WAIT), `rgb565_t` packed struct {r[4:0], g[5:0], b[4:0]}, and the H_ACTIVE/V_ACTIVE defaults.
- Sub-module `scanout_fifo`: synchronous FIFO, parameterised depth/width, with push, pop, `count`, `empty`, `full`.
- Top level holds the fetch FSM, frame/pixel-advance detection, skip counter, and RGB expansion.

## Test plan
- Reset, then release with Y stepped to 480: exactly 16 requests at addresses 0x00000..0x0000F, one outstanding; none further while the FIFO is full.
- SRAM model returns 0xF800 then 0x07E0. Scan to (0,0) then (1,0): RGB = FF/00/00, then 00/FF/00, one cycle after each advance.
- `doubleBuffer`=1 held across a frame boundary: the first request is at 0x4B000. Toggling `doubleBuffer` mid-frame does not change addresses.
- Model withholds `dataReady` for 3 pixel advances: RGB=0, `underflow`=1 sticky, the next 3 returned words are discarded, and pixel 3 shows word 3.
- Assert `Reset` in WAIT, then pulse `dataReady` 2 cycles later: FIFO stays empty and `queueRead` stays 0 until the next frame boundary.
- Run a full frame: exactly 307200 requests, last address 0x4AFFF, then the FSM is in IDLE with no further `queueRead`.
